dw_norm_seq: RTL
================

Name: dw_norm_seq

Overview:
- Sequential normalizer: the inverse companion of the team's combinational shifter.
- The shifter takes data plus a shift count and returns shifted data. This block takes data, derives the left-shift count that normalizes it, and returns the normalized data, the count and an exponent adjusted by that count.
- Iterative, one bit per clock.
- Valid/ready handshake on both sides; sits in front of floating-point pack and AGC datapaths.

Parameters:
- data_width, 16, data bus width; must be >= 2.
- sh_width, 4, width of shift-count output; max shift = min(2^sh_width - 1, data_width - 1).
- exp_width, 5, exponent width; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word (high only in IDLE).
- data_in  in  data_width  data to normalize.
- data_tc  in  1  0 = unsigned, 1 = two's complement.
- exp_in  in  exp_width  exponent associated with data_in.
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  downstream accepts result.
- data_out  out  data_width  normalized data.
- sh_out  out  sh_width  number of left shifts applied.
- exp_out  out  exp_width  exp_in - sh_out, modulo 2^exp_width.
- zero_flag  out  1  data_in was all zeros.
- exp_uflow  out  1  borrow occurred in exp_in - sh_out.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state = IDLE.
  - data_out, sh_out, exp_out, zero_flag, exp_uflow, out_valid all cleared to 0.
  - in_ready = 1 in the cycle after the reset edge.
  - rst overrides every other input; an in-flight word is discarded with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - Accept edge: in_valid & in_ready. On it, latch data_in, data_tc, exp_in; clear count to 0.
  - If data_in == 0, go to DONE with zero_flag = 1 and count = 0. Otherwise go to SHIFT.
- Normalized test, evaluated on the working register d:
  - Unsigned: d[msb] == 1.
  - Signed: d[msb] != d[msb-1].
- SHIFT, once per edge:
  - If d is normalized, or count == max shift: go to DONE.
  - Otherwise: d <= d << 1 (LSB padded with 0); count <= count + 1.
- Latency:
  - With n shifts, out_valid rises after edge n+1 counted from the accept edge.
  - Zero input: out_valid rises after the accept edge itself.
  - Already-normalized input: n = 0, so 1 edge.
- DONE:
  - out_valid = 1.
  - data_out = d, sh_out = count.
  - exp_out = exp_in - count, truncated to exp_width; exp_uflow = (exp_in < count).
  - All outputs held stable while out_ready = 0.
  - On out_valid & out_ready: go to IDLE. in_ready rises the following cycle; there is no same-cycle accept.
- in_valid is ignored outside IDLE. in_ready is 0 in SHIFT and DONE.
- Cap reached before normalization:
  - Result is the partially shifted data with sh_out = max shift.
  - No error flag; the caller detects this by checking the MSB.
- Signed all-ones (-1) normalizes to 1000...0 after data_width-1 shifts, within the cap when sh_width allows.
- Outputs outside DONE keep their last values; they are only meaningful while out_valid = 1.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (data_width=16, sh_width=4, exp_width=5 unless stated):
1. Unsigned 0x0010, exp_in=20 → data_out=0x8000, sh_out=11, exp_out=9, exp_uflow=0, zero_flag=0; out_valid rises 12 edges after accept.
2. Signed 0x0003, exp_in=5 → data_out=0x6000, sh_out=13, exp_out=24, exp_uflow=1. Then signed 0xFFF0 → data_out=0x8000, sh_out=11.
3. Zero and already-normalized inputs:
   - 0x0000 (either mode), exp_in=7 → out_valid after accept edge, data_out=0, sh_out=0, exp_out=7, zero_flag=1.
   - Unsigned 0x8001 → sh_out=0, out_valid after 1 edge.
4. Back-pressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 → outputs unchanged, in_ready=0, no new word accepted. Raise out_ready → IDLE; in_ready=1 next cycle; back-to-back word accepted.
5. Cap, with sh_width=3: unsigned 0x0001 → sh_out=7, data_out=0x0080, out_valid after 8 edges.
6. Reset mid-SHIFT (rst=1 on the 3rd shift edge) → next cycle: out_valid=0, all outputs 0, in_ready=1; a new word is then processed correctly.

Source files
------------

// File: rtl/dw_norm_seq.sv
// dw_norm_seq: iterative normalizer. Finds the left-shift count that
// normalizes a word (unsigned or two's complement), one bit per clock, and
// returns the normalized word, the count and the exponent reduced by it.
// Valid/ready handshake on both sides; every output is driven by a flop.
module dw_norm_seq #(
    parameter int data_width = 16,
    parameter int sh_width   = 4,
    parameter int exp_width  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] data_in,
    input  logic                  data_tc,
    input  logic [exp_width-1:0]  exp_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] data_out,
    output logic [sh_width-1:0]   sh_out,
    output logic [exp_width-1:0]  exp_out,
    output logic                  zero_flag,
    output logic                  exp_uflow
);

    // Largest shift the count can express without exceeding the word.
    localparam int CNT_LIMIT  = (1 << sh_width) - 1;
    localparam int MAX_SH_INT = (CNT_LIMIT < data_width - 1) ? CNT_LIMIT : data_width - 1;
    localparam logic [sh_width-1:0] MAX_SH = sh_width'(MAX_SH_INT);

    // Subtraction width: one bit wider than either operand so the top bit is the borrow.
    localparam int DIFF_W = ((exp_width > sh_width) ? exp_width : sh_width) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [data_width-1:0]   r_d;
    logic [sh_width-1:0]     r_cnt;
    logic [exp_width-1:0]    r_exp;
    logic                    r_tc;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [data_width-1:0]   r_data_out;
    logic [sh_width-1:0]     r_sh_out;
    logic [exp_width-1:0]    r_exp_out;
    logic                    r_zero_flag;
    logic                    r_exp_uflow;

    logic                    w_norm;
    logic                    w_in_zero;
    logic [DIFF_W-1:0]       w_diff;

    // Normalized: unsigned needs a set MSB; signed needs the top two bits to differ.
    assign w_norm    = r_tc ? (r_d[data_width-1] ^ r_d[data_width-2]) : r_d[data_width-1];
    assign w_in_zero = (data_in == '0);
    assign w_diff    = DIFF_W'(r_exp) - DIFF_W'(r_cnt);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = w_in_zero ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (w_norm || (r_cnt == MAX_SH)) w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Working register, shift counter and registered result/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d         <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_tc        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_sh_out    <= '0;
            r_exp_out   <= '0;
            r_zero_flag <= 1'b0;
            r_exp_uflow <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == ST_IDLE);
            r_out_valid <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_d   <= data_in;
                        r_tc  <= data_tc;
                        r_exp <= exp_in;
                        r_cnt <= '0;
                        // Zero input skips the shift loop and reports directly.
                        if (w_in_zero) begin
                            r_data_out  <= '0;
                            r_sh_out    <= '0;
                            r_exp_out   <= exp_in;
                            r_zero_flag <= 1'b1;
                            r_exp_uflow <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_next == ST_DONE) begin
                        r_data_out  <= r_d;
                        r_sh_out    <= r_cnt;
                        r_exp_out   <= w_diff[exp_width-1:0];
                        r_zero_flag <= 1'b0;
                        r_exp_uflow <= w_diff[DIFF_W-1];
                    end else begin
                        r_d   <= r_d << 1;
                        r_cnt <= r_cnt + sh_width'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign sh_out    = r_sh_out;
    assign exp_out   = r_exp_out;
    assign zero_flag = r_zero_flag;
    assign exp_uflow = r_exp_uflow;

endmodule
